// File: rtl/recv_b_pkg.sv
// recv_b shared types: receiver FSM states, widths, parity helper.
// Parity helper is also used by the xmit_b side of the link.
package recv_b_pkg;

   localparam int RECV_B_DATA_W      = 8;
   localparam int RECV_B_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } rx_state_e;

   // even parity bit: makes total count of ones even
   function automatic logic even_par(
      input logic [RECV_B_DATA_W-1:0] d
   );
      return ^d;
   endfunction

endpackage

// File: rtl/recv_b_sync.sv
// recv_b_sync: N-stage synchroniser for an idle-high line.
// Flops reset to 1 so reset never looks like a start bit.
module recv_b_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // shift the raw line through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '1;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/recv_b.sv
// recv_b: 8N1 (or 8E1 with RECV_B_PARITY_EN) serial receiver
// with valid/ready output, framing/overrun/parity error pulses.
module recv_b
   import recv_b_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     recv_b_in,
   input  logic                     recv_b_ready,
   output logic [RECV_B_DATA_W-1:0] recv_b_data,
   output logic                     recv_b_valid,
   output logic                     recv_b_ferr,
   output logic                     recv_b_ovr,
   output logic                     recv_b_perr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST = 3'(RECV_B_DATA_W - 1);

   logic                     rx_s;
   rx_state_e                state, state_n;
   logic [CW-1:0]            cnt, cnt_n;
   logic [2:0]               idx, idx_n;
   logic [RECV_B_DATA_W-1:0] sh, sh_n;
   logic                     dlv, dlv_n;
   logic                     ferr_n;
   logic                     tick;
`ifdef RECV_B_PARITY_EN
   logic                     pend, pend_n;
   logic                     perr_r, perr_n;
`endif

   recv_b_sync #(
      .STAGES (RECV_B_SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (recv_b_in),
      .q     (rx_s)
   );

   assign tick = (cnt == '0);

   // frame FSM and per-frame state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         sh          <= '0;
         dlv         <= 1'b0;
         recv_b_ferr <= 1'b0;
`ifdef RECV_B_PARITY_EN
         pend        <= 1'b0;
         perr_r      <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         sh          <= sh_n;
         dlv         <= dlv_n;
         recv_b_ferr <= ferr_n;
`ifdef RECV_B_PARITY_EN
         pend        <= pend_n;
         perr_r      <= perr_n;
`endif
      end
   end

   // next-state: mid-bit sampling driven by the bit counter
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      dlv_n   = 1'b0;
      ferr_n  = 1'b0;
`ifdef RECV_B_PARITY_EN
      pend_n  = pend;
      perr_n  = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               cnt_n   = HALF;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (!tick) begin
               cnt_n = cnt - CW'(1);
            end else if (!rx_s) begin
               cnt_n   = FULL;
               idx_n   = '0;
               state_n = ST_DATA;
`ifdef RECV_B_PARITY_EN
               pend_n  = 1'b0;
`endif
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!tick) begin
               cnt_n = cnt - CW'(1);
            end else begin
               sh_n[idx] = rx_s;
               cnt_n     = FULL;
               idx_n     = idx + 3'd1;
               if (idx == LAST) begin
`ifdef RECV_B_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end
            end
         end
`ifdef RECV_B_PARITY_EN
         ST_PARITY: begin
            if (!tick) begin
               cnt_n = cnt - CW'(1);
            end else begin
               if (rx_s != even_par(sh)) pend_n = 1'b1;
               cnt_n   = FULL;
               state_n = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (!tick) begin
               cnt_n = cnt - CW'(1);
            end else if (rx_s) begin
               state_n = ST_IDLE;
`ifdef RECV_B_PARITY_EN
               if (pend) perr_n = 1'b1;
               else      dlv_n  = 1'b1;
`else
               dlv_n = 1'b1;
`endif
            end else begin
               ferr_n  = 1'b1;
               state_n = ST_BRK;
            end
         end
         ST_BRK: begin
            if (rx_s) state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // output handshake: deliver, flag overrun, or retire on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         recv_b_data  <= '0;
         recv_b_valid <= 1'b0;
         recv_b_ovr   <= 1'b0;
      end else begin
         recv_b_ovr <= 1'b0;
         if (dlv) begin
            if (!recv_b_valid || recv_b_ready) begin
               recv_b_data  <= sh;
               recv_b_valid <= 1'b1;
            end else begin
               recv_b_ovr <= 1'b1;
            end
         end else if (recv_b_valid && recv_b_ready) begin
            recv_b_valid <= 1'b0;
         end
      end
   end

`ifdef RECV_B_PARITY_EN
   assign recv_b_perr = perr_r;
`else
   assign recv_b_perr = 1'b0;
`endif

endmodule

// File: tb/tb_recv_b.sv
// tb_recv_b: directed scenarios for recv_b, CLKS_PER_BIT = 16.
// Define RECV_B_PARITY_EN here as in the RTL build for 8E1 frames.
module tb_recv_b;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, ovr, perr;

   int total = 0;
   int bad   = 0;

   int         n_valid = 0;
   int         n_acc   = 0;
   int         n_ferr  = 0;
   int         n_ovr   = 0;
   int         n_perr  = 0;
   logic [7:0] last_acc = 8'h00;

   recv_b #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .recv_b_in    (line),
      .recv_b_ready (ready),
      .recv_b_data  (data),
      .recv_b_valid (valid),
      .recv_b_ferr  (ferr),
      .recv_b_ovr   (ovr),
      .recv_b_perr  (perr)
   );

   always #5 clk = ~clk;

   // event counters sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) n_valid++;
         if (valid && ready) begin
            n_acc++;
            last_acc = data;
         end
         if (ferr) n_ferr++;
         if (ovr)  n_ovr++;
         if (perr) n_perr++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bitw(input logic v, input int n);
      line = v;
      cyc(n);
   endtask

   task automatic send(
      input logic [7:0] b,
      input logic       par,
      input logic       stp
   );
      bitw(1'b0, CPB);
      for (int i = 0; i < 8; i++) bitw(b[i], CPB);
`ifdef RECV_B_PARITY_EN
      bitw(par, CPB);
`else
      if (par) begin end
`endif
      bitw(stp, CPB);
      line = 1'b1;
   endtask

   task automatic send_ok(input logic [7:0] b);
      send(b, ^b, 1'b1);
   endtask

   task automatic test_reset;
      cyc(3);
      total++;
      if ({valid, ferr, ovr, perr} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000",
                  {valid, ferr, ovr, perr});
      end
      total++;
      if (data !== 8'h00) begin
         bad++;
         $display("FAIL reset_data got=%h want=00", data);
      end
      rst_n = 1'b1;
      cyc(5);
   endtask

   task automatic test_single;
      int v0, a0, e0;
      v0 = n_valid;
      a0 = n_acc;
      e0 = n_ferr + n_ovr + n_perr;
      ready = 1'b1;
      send_ok(8'hA5);
      cyc(12);
      total++;
      if (n_valid - v0 !== 1) begin
         bad++;
         $display("FAIL single_valid_cycles got=%0d want=1", n_valid - v0);
      end
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'hA5) begin
         bad++;
         $display("FAIL single_data got=%h n=%0d want=a5 n=1",
                  last_acc, n_acc - a0);
      end
      total++;
      if (n_ferr + n_ovr + n_perr - e0 !== 0) begin
         bad++;
         $display("FAIL single_errs got=%0d want=0",
                  n_ferr + n_ovr + n_perr - e0);
      end
   endtask

   task automatic test_back_to_back;
      int a0, o0;
      a0 = n_acc;
      o0 = n_ovr;
      ready = 1'b0;
      send_ok(8'h3C);
      send_ok(8'hC3);
      cyc(12);
      total++;
      if (valid !== 1'b1 || data !== 8'h3C) begin
         bad++;
         $display("FAIL b2b_held got v=%b d=%h want v=1 d=3c", valid, data);
      end
      total++;
      if (n_ovr - o0 !== 1) begin
         bad++;
         $display("FAIL b2b_ovr got=%0d want=1", n_ovr - o0);
      end
      ready = 1'b1;
      cyc(1);
      ready = 1'b0;
      cyc(3);
      total++;
      if (valid !== 1'b0 || data !== 8'h3C) begin
         bad++;
         $display("FAIL b2b_drop got v=%b d=%h want v=0 d=3c", valid, data);
      end
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'h3C) begin
         bad++;
         $display("FAIL b2b_acc got n=%0d d=%h want n=1 d=3c",
                  n_acc - a0, last_acc);
      end
   endtask

   task automatic test_glitch;
      int v0, e0, a0;
      v0 = n_valid;
      e0 = n_ferr + n_ovr + n_perr;
      ready = 1'b1;
      bitw(1'b0, 5);
      bitw(1'b1, 30);
      total++;
      if (n_valid - v0 !== 0 || n_ferr + n_ovr + n_perr - e0 !== 0) begin
         bad++;
         $display("FAIL glitch_quiet got v=%0d e=%0d want 0 0",
                  n_valid - v0, n_ferr + n_ovr + n_perr - e0);
      end
      a0 = n_acc;
      send_ok(8'h55);
      cyc(12);
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'h55) begin
         bad++;
         $display("FAIL glitch_next got n=%0d d=%h want n=1 d=55",
                  n_acc - a0, last_acc);
      end
   endtask

   task automatic test_break;
      int v0, f0, a0;
      v0 = n_valid;
      f0 = n_ferr;
      ready = 1'b1;
      send(8'h81, ^8'h81, 1'b0);
      bitw(1'b0, 40 * CPB);
      bitw(1'b1, 20);
      total++;
      if (n_ferr - f0 !== 1) begin
         bad++;
         $display("FAIL brk_ferr got=%0d want=1", n_ferr - f0);
      end
      total++;
      if (n_valid - v0 !== 0) begin
         bad++;
         $display("FAIL brk_valid got=%0d want=0", n_valid - v0);
      end
      a0 = n_acc;
      send_ok(8'h7E);
      cyc(12);
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'h7E) begin
         bad++;
         $display("FAIL brk_next got n=%0d d=%h want n=1 d=7e",
                  n_acc - a0, last_acc);
      end
   endtask

`ifdef RECV_B_PARITY_EN
   task automatic test_parity;
      int v0, p0, f0, a0;
      v0 = n_valid;
      p0 = n_perr;
      f0 = n_ferr;
      ready = 1'b1;
      send(8'h07, 1'b0, 1'b1);
      cyc(12);
      total++;
      if (n_perr - p0 !== 1 || n_ferr - f0 !== 0) begin
         bad++;
         $display("FAIL par_bad got p=%0d f=%0d want p=1 f=0",
                  n_perr - p0, n_ferr - f0);
      end
      total++;
      if (n_valid - v0 !== 0) begin
         bad++;
         $display("FAIL par_novalid got=%0d want=0", n_valid - v0);
      end
      a0 = n_acc;
      p0 = n_perr;
      send(8'h07, 1'b1, 1'b1);
      cyc(12);
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'h07 || n_perr - p0 !== 0) begin
         bad++;
         $display("FAIL par_good got n=%0d d=%h p=%0d want n=1 d=07 p=0",
                  n_acc - a0, last_acc, n_perr - p0);
      end
   endtask
`else
   task automatic test_parity;
      int p0;
      p0 = n_perr;
      ready = 1'b1;
      send_ok(8'h07);
      cyc(12);
      total++;
      if (n_perr - p0 !== 0 || last_acc !== 8'h07) begin
         bad++;
         $display("FAIL nopar got p=%0d d=%h want p=0 d=07",
                  n_perr - p0, last_acc);
      end
   endtask
`endif

   task automatic test_reset_mid;
      int v0, a0, e0;
      ready = 1'b1;
      bitw(1'b0, CPB);
      bitw(1'b1, 4 * CPB + 8);
      rst_n = 1'b0;
      cyc(3);
      total++;
      if ({valid, ferr, ovr, perr} !== 4'b0000 || data !== 8'h00) begin
         bad++;
         $display("FAIL rstmid_outs got f=%b d=%h want f=0000 d=00",
                  {valid, ferr, ovr, perr}, data);
      end
      rst_n = 1'b1;
      v0 = n_valid;
      e0 = n_ferr + n_ovr + n_perr;
      bitw(1'b1, 10 * CPB);
      total++;
      if (n_valid - v0 !== 0 || n_ferr + n_ovr + n_perr - e0 !== 0) begin
         bad++;
         $display("FAIL rstmid_quiet got v=%0d e=%0d want 0 0",
                  n_valid - v0, n_ferr + n_ovr + n_perr - e0);
      end
      a0 = n_acc;
      send_ok(8'h12);
      cyc(12);
      total++;
      if (n_acc - a0 !== 1 || last_acc !== 8'h12) begin
         bad++;
         $display("FAIL rstmid_next got n=%0d d=%h want n=1 d=12",
                  n_acc - a0, last_acc);
      end
   endtask

   initial begin
      #1;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_break;
      test_parity;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
